// File: rtl/pulsadores_pkg.sv
// Shared constants for the pushbutton conditioning block: clock default,
// debounce window derivation and button index map.
package pulsadores_pkg;

  localparam int FREQ_HZ_DEF     = 4000000;
  localparam int DEBOUNCE_MS_DEF = 20;
  localparam int CNT_W_DEF       = 17;

  localparam int BTN1 = 0;
  localparam int BTN2 = 1;
  localparam int BTN3 = 2;

  // Divide first so large clock rates do not overflow 32-bit arithmetic.
  function automatic int deb_cycles(input int freq_hz, input int debounce_ms);
    return (freq_hz / 1000) * debounce_ms;
  endfunction

endpackage

// File: rtl/debounce_canal.sv
// Single pushbutton channel: two-flop synchroniser, stable-window counter
// and registered press pulse on an accepted not-pressed to pressed change.
module debounce_canal
  import pulsadores_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic press,
  output logic press_d
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             settle;

  // Terminal count with a still-differing input: the new level is accepted.
  assign settle  = (s2 != level) && (cnt == CNT_LAST);
  assign press_d = settle && s2;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= pin;
      s2    <= s1;
      press <= press_d;
      if (s2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/debounce_pulsadores.sv
// Conditions the three raw board pushbuttons into clean pressed levels
// P1..P3 plus per-button and combined one-cycle press pulses.
module debounce_pulsadores
  import pulsadores_pkg::*;
#(
  parameter int FREQ_HZ       = FREQ_HZ_DEF,
  parameter int DEBOUNCE_MS   = DEBOUNCE_MS_DEF,
  parameter int DEB_CYCLES    = deb_cycles(FREQ_HZ, DEBOUNCE_MS),
  parameter int CNT_W         = CNT_W_DEF,
  parameter int IN_ACTIVE_LOW = 1
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic [2:0] btn_raw,
  output logic       P1,
  output logic       P2,
  output logic       P3,
  output logic [2:0] press,
  output logic       any_press
);

  localparam logic [2:0] IN_INV = (IN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  logic [2:0] pin;
  logic [2:0] level;
  logic [2:0] press_d;

  // After this, 1 always means pressed regardless of board wiring.
  assign pin = btn_raw ^ IN_INV;

  for (genvar i = 0; i < 3; i++) begin : g_canal
    debounce_canal #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_canal (
      .clk_in (clk_in),
      .reset_n(reset_n),
      .pin    (pin[i]),
      .level  (level[i]),
      .press  (press[i]),
      .press_d(press_d[i])
    );
  end

  assign P1 = level[BTN1];
  assign P2 = level[BTN2];
  assign P3 = level[BTN3];

  // Registered from the same next-state terms as press so both line up.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_d;
    end
  end

endmodule

// File: tb/tb_debounce_pulsadores.sv
// Scoreboard bench for debounce_pulsadores: directed scenarios then random
// button activity, checked against a behavioural debounce model.
module tb_debounce_pulsadores;

  localparam int DEB = 4;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] btn_raw = 3'b000;
  logic       P1, P2, P3, any_press;
  logic [2:0] press;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] lvl;
    logic [2:0] prs;
    logic       any;
  } exp_t;

  exp_t exp_q[$];

  debounce_pulsadores #(
    .FREQ_HZ      (1000),
    .DEBOUNCE_MS  (4),
    .IN_ACTIVE_LOW(1)
  ) dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .P1       (P1),
    .P2       (P2),
    .P3       (P3),
    .press    (press),
    .any_press(any_press)
  );

  always #5 clk_in = ~clk_in;

  // Reference: a channel sees its pressed value two edges late; the output
  // flips once that delayed value has disagreed with it for DEB edges in a row.
  logic [2:0] hist1 = 3'b000;
  logic [2:0] hist2 = 3'b000;
  int         run[3] = '{0, 0, 0};
  logic [2:0] m_lvl = 3'b000;

  always @(posedge clk_in) begin
    exp_t       e;
    logic [2:0] seen;
    logic [2:0] pressed_now;
    pressed_now = ~btn_raw;
    e.prs = 3'b000;
    if (!reset_n) begin
      hist1 = 3'b000;
      hist2 = 3'b000;
      m_lvl = 3'b000;
      for (int c = 0; c < 3; c++) run[c] = 0;
    end else begin
      seen  = hist2;
      hist2 = hist1;
      hist1 = pressed_now;
      for (int c = 0; c < 3; c++) begin
        if (seen[c] == m_lvl[c]) begin
          run[c] = 0;
        end else begin
          run[c] = run[c] + 1;
          if (run[c] >= DEB) begin
            m_lvl[c] = seen[c];
            e.prs[c] = seen[c];
            run[c]   = 0;
          end
        end
      end
    end
    e.lvl = m_lvl;
    e.any = |e.prs;
    exp_q.push_back(e);
  end

  always @(negedge clk_in) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.lvl = {P3, P2, P1};
      a.prs = press;
      a.any = any_press;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got P3..P1=%b press=%b any=%b, required P3..P1=%b press=%b any=%b",
                 $time, a.lvl, a.prs, a.any, e.lvl, e.prs, e.any);
      end
    end
  end

  task automatic drive(input logic r, input logic [2:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      reset_n = r;
      btn_raw = b;
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    logic [2:0] b;
    int         hold[3];

    // Reset with all buttons pressed, then release reset.
    drive(1'b0, 3'b000, 3);
    drive(1'b1, 3'b000, 10);
    drive(1'b1, 3'b111, 10);
    // Clean press and release of button 1.
    drive(1'b1, 3'b110, 10);
    drive(1'b1, 3'b111, 10);
    // Bounce on button 1, then a long hold.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'b110, 2);
      drive(1'b1, 3'b111, 1);
    end
    drive(1'b1, 3'b110, 10);
    drive(1'b1, 3'b111, 10);
    // Buttons 2 and 3 together.
    drive(1'b1, 3'b001, 10);
    drive(1'b1, 3'b111, 10);
    // Reset in the middle of a count.
    drive(1'b1, 3'b110, 3);
    drive(1'b0, 3'b110, 1);
    drive(1'b1, 3'b110, 10);
    drive(1'b1, 3'b111, 10);

    // Random per-button hold times, short ones acting as bounce.
    b = 3'b111;
    for (int c = 0; c < 3; c++) hold[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          b[c]    = ~b[c];
          hold[c] = int'($urandom_range(1, 9));
        end
        hold[c]--;
      end
      drive(($urandom_range(0, 399) != 0), b, 1);
    end

    drive(1'b1, 3'b111, 12);
    @(negedge clk_in);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
